icache_req_arbiter: RTL and testbench

- Round-robin arbiter between the 32 tile requestors and the shared 4 KB instruction cache. Sits directly upstream of the 1-to-32 cache response data demultiplexer.
- Grants one requestor at a time. Captures that requestor's fetch address from the wired-OR address bus and issues it to the cache with a valid/ready handshake.
- On the cache response, drives the demultiplexer's data, 5-bit selection and enable for exactly one cycle.
- Only one transaction is outstanding at a time.

---
 rtl/icache_req_arbiter.sv | 92 +++++++++
 tb/tb_icache_req_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/icache_req_arbiter.sv
// Round-robin arbiter from the tile fetch requestors to the shared instruction cache.
// It runs one transaction at a time and ends each one with a single-cycle pulse to the response demux.
module icache_req_arbiter #(
    parameter int SEL_W  = 5,
    parameter int N_REQ  = 2**SEL_W,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_REQ-1:0]  req,
    input  logic [ADDR_W-1:0] bus_addr,
    output logic [N_REQ-1:0]  grant,
    output logic              cache_req_valid,
    input  logic              cache_req_ready,
    output logic [ADDR_W-1:0] cache_addr,
    input  logic              cache_resp_valid,
    input  logic [DATA_W-1:0] cache_resp_data,
    output logic [DATA_W-1:0] dmx_data,
    output logic [SEL_W-1:0]  dmx_sel,
    output logic              dmx_en,
    output logic              busy
);

    typedef enum logic [2:0] {IDLE, GRANT, CREQ, WAIT, DELIVER} state_t;

    state_t           state, state_nx;
    logic [SEL_W-1:0] ptr, idx, win, scan;
    logic             win_vld;
    logic             hold;

    // Scan from the highest offset down, so the lowest offset from ptr is written last and wins.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        scan    = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            scan = ptr + SEL_W'(i);
            if (req[scan]) begin
                win     = scan;
                win_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (win_vld) state_nx = GRANT;
            GRANT:   state_nx = CREQ;
            CREQ:    if (cache_req_ready) state_nx = WAIT;
            WAIT:    if (cache_resp_valid) state_nx = DELIVER;
            DELIVER: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= '0;
            idx        <= '0;
            cache_addr <= '0;
            dmx_data   <= '0;
            dmx_sel    <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE:    if (win_vld) idx <= win;
                GRANT:   cache_addr <= bus_addr;
                WAIT: if (cache_resp_valid) begin
                    dmx_data <= cache_resp_data;
                    dmx_sel  <= idx;
                end
                DELIVER: ptr <= idx + 1'b1;
                default: ;
            endcase
        end
    end

    // Grant is decoded from the registered idx, so at most one bit can ever be set.
    assign hold = (state == GRANT) || (state == CREQ) || (state == WAIT);

    for (genvar g = 0; g < N_REQ; g++) begin : g_grant
        assign grant[g] = hold && (idx == SEL_W'(g));
    end

    assign cache_req_valid = (state == CREQ);
    assign dmx_en          = (state == DELIVER);
    assign busy            = (state != IDLE);

endmodule

// File: tb/tb_icache_req_arbiter.sv
// Directed bench for icache_req_arbiter: a transaction table plus hand-written corner sequences.
module tb_icache_req_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] req;
    logic [31:0] bus_addr;
    logic [31:0] grant;
    logic        cache_req_valid;
    logic        cache_req_ready;
    logic [31:0] cache_addr;
    logic        cache_resp_valid;
    logic [31:0] cache_resp_data;
    logic [31:0] dmx_data;
    logic [4:0]  dmx_sel;
    logic        dmx_en;
    logic        busy;

    icache_req_arbiter dut (
        .clk(clk), .rst_n(rst_n), .req(req), .bus_addr(bus_addr), .grant(grant),
        .cache_req_valid(cache_req_valid), .cache_req_ready(cache_req_ready),
        .cache_addr(cache_addr), .cache_resp_valid(cache_resp_valid),
        .cache_resp_data(cache_resp_data), .dmx_data(dmx_data), .dmx_sel(dmx_sel),
        .dmx_en(dmx_en), .busy(busy)
    );

    always #5 clk = ~clk;

    // Requestor model: each granted tile drives its own address onto the wired-OR bus.
    logic [31:0] raddr [32];
    always_comb begin
        bus_addr = '0;
        for (int i = 0; i < 32; i++)
            if (grant[i]) bus_addr = bus_addr | raddr[i];
    end

    typedef struct {
        logic [31:0] req;
        int          stall;
        int          rdly;
        logic [31:0] data;
        int          exp_idx;
    } vec_t;

    vec_t tbl[$];
    int   nvec = 0;
    int   nerr = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic do_txn(input vec_t v);
        logic [31:0] oh;
        int n;
        oh = 32'd1 << v.exp_idx;
        req = v.req;
        cache_req_ready = 1'b0;
        cache_resp_valid = 1'b0;
        n = 0;
        while (grant == 32'd0 && n < 8) begin
            tick();
            n++;
        end
        chk("grant", grant, oh);
        chk("busy", busy, 1);
        tick();
        for (int s = 0; s <= v.stall; s++) begin
            chk("creq_valid", cache_req_valid, 1);
            chk("creq_addr", cache_addr, raddr[v.exp_idx]);
            chk("creq_grant", grant, oh);
            chk("creq_no_en", dmx_en, 0);
            if (s < v.stall) tick();
        end
        cache_req_ready = 1'b1;
        tick();
        cache_req_ready = 1'b0;
        for (int r = 0; r < v.rdly; r++) begin
            chk("wait_valid", cache_req_valid, 0);
            chk("wait_no_en", dmx_en, 0);
            tick();
        end
        cache_resp_valid = 1'b1;
        cache_resp_data = v.data;
        tick();
        cache_resp_valid = 1'b0;
        cache_resp_data = 32'h5555_AAAA;
        chk("dlv_en", dmx_en, 1);
        chk("dlv_sel", dmx_sel, v.exp_idx[4:0]);
        chk("dlv_data", dmx_data, v.data);
        chk("dlv_grant", grant, 0);
    endtask

    initial begin
        vec_t v;
        for (int i = 0; i < 32; i++) raddr[i] = 32'h0001_0000 + i * 32'h44;
        raddr[2] = 32'h0000_1A40;

        // Sweep from reset: all requesting for 33 transactions, then the wrap cases.
        for (int k = 0; k < 33; k++) begin
            v.req = 32'hFFFF_FFFF; v.stall = k % 3; v.rdly = k % 2;
            v.data = 32'hC0DE_0000 + k * 32'h111; v.exp_idx = k % 32;
            tbl.push_back(v);
        end
        v.req = 32'h2000_0000; v.stall = 0; v.rdly = 0; v.data = 32'h2929_2929; v.exp_idx = 29;
        tbl.push_back(v);
        v.req = 32'h8000_0001; v.stall = 0; v.rdly = 1; v.data = 32'h3131_3131; v.exp_idx = 31;
        tbl.push_back(v);
        v.req = 32'h8000_0001; v.stall = 1; v.rdly = 0; v.data = 32'h0000_0F0F; v.exp_idx = 0;
        tbl.push_back(v);
        v.req = 32'h8000_0001; v.stall = 5; v.rdly = 2; v.data = 32'hFACE_B00C; v.exp_idx = 31;
        tbl.push_back(v);

        rst_n = 1'b0; req = '0; cache_req_ready = 1'b0;
        cache_resp_valid = 1'b0; cache_resp_data = '0;
        tick(); tick();
        chk("rst_grant", grant, 0);
        chk("rst_valid", cache_req_valid, 0);
        chk("rst_addr", cache_addr, 0);
        chk("rst_data", dmx_data, 0);
        chk("rst_sel", dmx_sel, 0);
        chk("rst_en", dmx_en, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;

        // Single request at minimum latency.
        req = 32'h0000_0004; cache_req_ready = 1'b1;
        tick();
        chk("t1_grant_c1", grant, 32'h4);
        chk("t1_valid_c1", cache_req_valid, 0);
        tick();
        chk("t1_valid_c2", cache_req_valid, 1);
        chk("t1_addr_c2", cache_addr, 32'h0000_1A40);
        tick();
        cache_resp_valid = 1'b1; cache_resp_data = 32'hDEAD_BEEF;
        chk("t1_valid_c3", cache_req_valid, 0);
        chk("t1_en_c3", dmx_en, 0);
        tick();
        cache_resp_valid = 1'b0; req = '0; cache_req_ready = 1'b0;
        chk("t1_en_c4", dmx_en, 1);
        chk("t1_sel_c4", dmx_sel, 2);
        chk("t1_data_c4", dmx_data, 32'hDEAD_BEEF);
        tick();
        chk("t1_en_c5", dmx_en, 0);
        chk("t1_busy_c5", busy, 0);
        // ptr is now 3: with everyone requesting, 3 wins.
        req = 32'hFFFF_FFFF;
        tick();
        chk("t1_ptr", grant, 32'h8);

        rst_n = 1'b0; req = '0;
        tick();
        rst_n = 1'b1;
        foreach (tbl[i]) do_txn(tbl[i]);

        // Spurious response in IDLE; outputs hold after DELIVER.
        req = '0;
        tick();
        cache_resp_valid = 1'b1; cache_resp_data = 32'hBAD0_BAD0;
        tick();
        cache_resp_valid = 1'b0;
        chk("sp_idle_en", dmx_en, 0);
        chk("sp_idle_busy", busy, 0);
        chk("hold_sel", dmx_sel, 31);
        chk("hold_data", dmx_data, 32'hFACE_B00C);

        // ready and resp together in CREQ: the response must be dropped.
        req = 32'h0000_0020;
        tick();
        chk("sp_creq_grant", grant, 32'h20);
        tick();
        cache_req_ready = 1'b1; cache_resp_valid = 1'b1; cache_resp_data = 32'hBAD1_BAD1;
        tick();
        cache_req_ready = 1'b0; cache_resp_valid = 1'b0;
        chk("sp_creq_en", dmx_en, 0);
        chk("sp_creq_busy", busy, 1);
        tick();
        chk("sp_creq_en2", dmx_en, 0);
        chk("sp_creq_grant2", grant, 32'h20);

        // Reset while in WAIT abandons the transaction.
        rst_n = 1'b0;
        tick();
        chk("wrst_grant", grant, 0);
        chk("wrst_valid", cache_req_valid, 0);
        chk("wrst_addr", cache_addr, 0);
        chk("wrst_data", dmx_data, 0);
        chk("wrst_sel", dmx_sel, 0);
        chk("wrst_en", dmx_en, 0);
        chk("wrst_busy", busy, 0);
        rst_n = 1'b1; req = '0; cache_resp_valid = 1'b1;
        tick();
        cache_resp_valid = 1'b0;
        chk("wrst_late_en", dmx_en, 0);
        chk("wrst_late_busy", busy, 0);
        v.req = 32'hFFFF_FFFF; v.stall = 0; v.rdly = 0; v.data = 32'h0A0A_0A0A; v.exp_idx = 0;
        do_txn(v);

        // Requestor 7 drops its request while in CREQ; 9 is served next, not 7.
        req = 32'h0000_0280;
        tick(); tick();
        chk("drop_grant", grant, 32'h80);
        tick();
        req = 32'h0000_0200;
        chk("drop_creq", cache_req_valid, 1);
        cache_req_ready = 1'b1;
        tick();
        cache_req_ready = 1'b0; cache_resp_valid = 1'b1; cache_resp_data = 32'h7777_0007;
        tick();
        cache_resp_valid = 1'b0;
        chk("drop_en", dmx_en, 1);
        chk("drop_sel", dmx_sel, 7);
        chk("drop_data", dmx_data, 32'h7777_0007);
        v.req = 32'h0000_0200; v.stall = 0; v.rdly = 0; v.data = 32'h9999_0009; v.exp_idx = 9;
        do_txn(v);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
